psum_mem_arbiter: RTL

Shares the single-port PSUM SRAM between two requesters: the accumulation writer (OFIFO drain, port "acc") and the SFU array controller (port "sfu").
- Owner-based, burst-locked arbitration with round-robin tie-break and a burst-length cap, so a long SFU pass cannot starve accumulation, or the reverse.
- Muxes address, enables and write data to the SRAM.
- Returns a tagged read-valid one cycle after each granted read.
- Sits between OFIFO/SFU control and the PSUM SRAM macro.

---
 rtl/psum_mem_arbiter_pkg.sv | 25 ++
 rtl/psum_arb_fsm.sv | 102 ++++++++++
 rtl/psum_mem_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/psum_mem_arbiter_pkg.sv
// rtl/psum_mem_arbiter_pkg.sv - shared owner encoding and requester IDs for the PSUM SRAM arbiter
package psum_mem_arbiter_pkg;

   // Who currently owns the PSUM SRAM port
   typedef enum logic [1:0] {
      OWNER_IDLE = 2'd0,
      OWNER_ACC  = 2'd1,
      OWNER_SFU  = 2'd2
   } owner_e;

   // Requester indices into the packed req/gnt vectors
   localparam int   NUM_REQ = 2;
   localparam logic REQ_ACC = 1'b0;
   localparam logic REQ_SFU = 1'b1;

   // The opposite requester of an owning state; IDLE has no opposite
   function automatic owner_e other_owner(input owner_e o);
      case (o)
         OWNER_ACC: return OWNER_SFU;
         OWNER_SFU: return OWNER_ACC;
         default:   return OWNER_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/psum_arb_fsm.sv
// rtl/psum_arb_fsm.sv - burst-locked round-robin owner FSM (optional counters: PSUM_ARB_STATS_EN)
module psum_arb_fsm
   import psum_mem_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 16
)(
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output owner_e             owner_o
`ifdef PSUM_ARB_STATS_EN
   ,
   output logic [31:0]        stat_acc_grants_o,
   output logic [31:0]        stat_sfu_grants_o,
   output logic [31:0]        stat_wait_cycles_o
`endif
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

   owner_e            owner_q, owner_d;
   owner_e            last_owner_q;
   logic [CNT_W-1:0]  burst_cnt_q;
   logic              own_req, oth_req;

   assign owner_o        = owner_q;
   assign gnt_o[REQ_ACC] = (owner_q == OWNER_ACC);
   assign gnt_o[REQ_SFU] = (owner_q == OWNER_SFU);

   // Next owner: idle picks requester (tie goes away from last owner); owner keeps until it drops or hits the burst cap
   always_comb begin
      owner_d = owner_q;
      own_req = 1'b0;
      oth_req = 1'b0;
      case (owner_q)
         OWNER_ACC: begin
            own_req = req_i[REQ_ACC];
            oth_req = req_i[REQ_SFU];
         end
         OWNER_SFU: begin
            own_req = req_i[REQ_SFU];
            oth_req = req_i[REQ_ACC];
         end
         default: ;
      endcase

      if (owner_q == OWNER_IDLE) begin
         if (req_i[REQ_ACC] && req_i[REQ_SFU])
            owner_d = other_owner(last_owner_q);
         else if (req_i[REQ_ACC])
            owner_d = OWNER_ACC;
         else if (req_i[REQ_SFU])
            owner_d = OWNER_SFU;
      end else if (!own_req) begin
         owner_d = oth_req ? other_owner(owner_q) : OWNER_IDLE;
      end else if (oth_req && (burst_cnt_q == BURST_LAST)) begin
         owner_d = other_owner(owner_q);
      end
   end

   // Owner, burst counter (only advances while the other side waits) and last owner for the tie-break
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         owner_q      <= OWNER_IDLE;
         burst_cnt_q  <= '0;
         last_owner_q <= OWNER_SFU;
      end else begin
         owner_q <= owner_d;
         if ((owner_d != owner_q) || (owner_q == OWNER_IDLE))
            burst_cnt_q <= '0;
         else if (oth_req)
            burst_cnt_q <= burst_cnt_q + 1'b1;
         if ((owner_d != owner_q) && (owner_d != OWNER_IDLE))
            last_owner_q <= owner_d;
      end
   end

`ifdef PSUM_ARB_STATS_EN
   logic waiting;
   assign waiting = (req_i[REQ_ACC] && (owner_q != OWNER_ACC)) ||
                    (req_i[REQ_SFU] && (owner_q != OWNER_SFU));

   // Saturating counters of ownership entries per side and of cycles where someone waits
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stat_acc_grants_o  <= '0;
         stat_sfu_grants_o  <= '0;
         stat_wait_cycles_o <= '0;
      end else begin
         if ((owner_d != owner_q) && (owner_d == OWNER_ACC) && (stat_acc_grants_o != '1))
            stat_acc_grants_o <= stat_acc_grants_o + 32'd1;
         if ((owner_d != owner_q) && (owner_d == OWNER_SFU) && (stat_sfu_grants_o != '1))
            stat_sfu_grants_o <= stat_sfu_grants_o + 32'd1;
         if (waiting && (stat_wait_cycles_o != '1))
            stat_wait_cycles_o <= stat_wait_cycles_o + 32'd1;
      end
   end
`endif

endmodule

// File: rtl/psum_mem_arbiter.sv
// rtl/psum_mem_arbiter.sv - PSUM SRAM arbiter between accumulation writer and SFU (optional counters: PSUM_ARB_STATS_EN)
module psum_mem_arbiter
   import psum_mem_arbiter_pkg::*;
#(
   parameter int col       = 8,
   parameter int psum_bw   = 16,
   parameter int ADDR_W    = 11,
   parameter int MAX_BURST = 16
)(
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    acc_req_i,
   input  logic [ADDR_W-1:0]       acc_addr_i,
   input  logic                    acc_rd_en_i,
   input  logic                    acc_wr_en_i,
   input  logic [col*psum_bw-1:0]  acc_wdata_i,
   output logic                    acc_gnt_o,
   output logic                    acc_rd_vld_o,
   input  logic                    sfu_req_i,
   input  logic [ADDR_W-1:0]       sfu_addr_i,
   input  logic                    sfu_rd_en_i,
   input  logic                    sfu_wr_en_i,
   input  logic [col*psum_bw-1:0]  sfu_wdata_i,
   output logic                    sfu_gnt_o,
   output logic                    sfu_rd_vld_o,
   output logic [ADDR_W-1:0]       mem_addr_o,
   output logic                    mem_rd_en_o,
   output logic                    mem_wr_en_o,
   output logic [col*psum_bw-1:0]  mem_wdata_o,
   output logic                    conflict_err_o
`ifdef PSUM_ARB_STATS_EN
   ,
   output logic [31:0]             stat_acc_grants_o,
   output logic [31:0]             stat_sfu_grants_o,
   output logic [31:0]             stat_wait_cycles_o
`endif
);

   logic [NUM_REQ-1:0] req, gnt;
   owner_e             owner;
   logic               own_rd, own_wr;
   logic               acc_rd_vld_q, sfu_rd_vld_q, conflict_err_q;

   assign req[REQ_ACC] = acc_req_i;
   assign req[REQ_SFU] = sfu_req_i;
   assign acc_gnt_o    = gnt[REQ_ACC];
   assign sfu_gnt_o    = gnt[REQ_SFU];

   psum_arb_fsm #(
      .MAX_BURST (MAX_BURST)
   ) u_fsm (
      .clk_i              (clk_i),
      .reset_i            (reset_i),
      .req_i              (req),
      .gnt_o              (gnt),
      .owner_o            (owner)
`ifdef PSUM_ARB_STATS_EN
      ,
      .stat_acc_grants_o  (stat_acc_grants_o),
      .stat_sfu_grants_o  (stat_sfu_grants_o),
      .stat_wait_cycles_o (stat_wait_cycles_o)
`endif
   );

   // SRAM mux: only the owner reaches the macro; a simultaneous rd+wr keeps the write and drops the read
   always_comb begin
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      own_rd      = 1'b0;
      own_wr      = 1'b0;
      case (owner)
         OWNER_ACC: begin
            mem_addr_o  = acc_addr_i;
            mem_wdata_o = acc_wdata_i;
            own_rd      = acc_rd_en_i;
            own_wr      = acc_wr_en_i;
         end
         OWNER_SFU: begin
            mem_addr_o  = sfu_addr_i;
            mem_wdata_o = sfu_wdata_i;
            own_rd      = sfu_rd_en_i;
            own_wr      = sfu_wr_en_i;
         end
         default: ;
      endcase
      mem_wr_en_o = own_wr;
      mem_rd_en_o = own_rd && !own_wr;
   end

   // Read-valid tagged with the owner at issue time, plus the sticky rd/wr conflict flag
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         acc_rd_vld_q   <= 1'b0;
         sfu_rd_vld_q   <= 1'b0;
         conflict_err_q <= 1'b0;
      end else begin
         acc_rd_vld_q   <= mem_rd_en_o && (owner == OWNER_ACC);
         sfu_rd_vld_q   <= mem_rd_en_o && (owner == OWNER_SFU);
         conflict_err_q <= conflict_err_q || (own_rd && own_wr);
      end
   end

   assign acc_rd_vld_o   = acc_rd_vld_q;
   assign sfu_rd_vld_o   = sfu_rd_vld_q;
   assign conflict_err_o = conflict_err_q;

endmodule
